// File: rtl/sysconfig_pkg.sv
// Shared core configuration: default datapath widths and RISC-V load funct3 encodings.
package sysconfig;

  localparam int XLEN_DEF   = 64;
  localparam int REG_AW_DEF = 5;
  localparam int CSR_AW_DEF = 12;
  localparam int CNT_W_DEF  = 64;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_f3_e;

endpackage

// File: rtl/wb_load_fmt.sv
// Combinational load aligner/extender: shifts raw load data down by the byte offset,
// then sign- or zero-extends the selected byte/half/word/double.
module wb_load_fmt
  import sysconfig::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            load_en_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic [1:0]      sz,
                                             input logic            zext);
    logic signed [XLEN-1:0] s;
    logic        [XLEN-1:0] u;
    s = v;
    u = v;
    case (sz)
      2'b00: begin
        s = XLEN'($signed(v[7:0]));
        u = XLEN'(v[7:0]);
      end
      2'b01: begin
        s = XLEN'($signed(v[15:0]));
        u = XLEN'(v[15:0]);
      end
      2'b10: begin
        s = XLEN'($signed(v[31:0]));
        u = XLEN'(v[31:0]);
      end
      default: begin
        s = v;
        u = v;
      end
    endcase
    return zext ? u : s;
  endfunction

  logic [5:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic [1:0]      size;

  always_comb begin
    // On RV32 the doubleword offset bit does not exist and LD/LWU collapse onto LW.
    shamt   = (XLEN == 64) ? {addr_lo_i, 3'b000} : {1'b0, addr_lo_i[1:0], 3'b000};
    shifted = data_i >> shamt;
    size    = funct3_i[1:0];
    if ((XLEN != 64) && (size == 2'b11)) size = 2'b10;
    data_o  = load_en_i ? extend(shifted, size, funct3_i[2]) : data_i;
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: one-entry valid/ready register feeding GPR and CSR write
// ports, load formatting on entry, and a retired-instruction counter.
// Optional build macro WB_COMMIT_TRACE_EN adds pc/inst capture and commit trace outputs.
module wb_stage
  import sysconfig::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CSR_AW = CSR_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [REG_AW-1:0] rd_idx_i,
  input  logic              rd_wen_i,
  input  logic              load_en_i,
  input  logic [2:0]        load_f3_i,
  input  logic [2:0]        addr_lo_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [XLEN-1:0]   csr_data_i,
  input  logic              csr_wen_i,
  input  logic              stall_i,
  input  logic              flush_i,
`ifdef WB_COMMIT_TRACE_EN
  input  logic [XLEN-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  output logic              commit_valid_o,
  output logic [XLEN-1:0]   commit_pc_o,
  output logic [31:0]       commit_inst_o,
`endif
  output logic              gpr_wen_o,
  output logic [REG_AW-1:0] gpr_idx_o,
  output logic [XLEN-1:0]   gpr_data_o,
  output logic              csr_wen_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic [XLEN-1:0]   csr_data_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  logic [XLEN-1:0] fmt_data;

  wb_load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .load_en_i (load_en_i),
    .data_i    (mem_data_i),
    .addr_lo_i (addr_lo_i),
    .funct3_i  (load_f3_i),
    .data_o    (fmt_data)
  );

  logic              valid_q,    valid_d;
  logic [REG_AW-1:0] rd_idx_q,   rd_idx_d;
  logic              rd_wen_q,   rd_wen_d;
  logic [XLEN-1:0]   data_q,     data_d;
  logic [CSR_AW-1:0] csr_addr_q, csr_addr_d;
  logic [XLEN-1:0]   csr_data_q, csr_data_d;
  logic              csr_wen_q,  csr_wen_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
`ifdef WB_COMMIT_TRACE_EN
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [31:0]       inst_q,     inst_d;
`endif

  logic retire;
  logic accept;

  assign retire      = valid_q && !stall_i;
  assign mem_ready_o = !flush_i && (!valid_q || !stall_i);
  assign accept      = mem_valid_i && mem_ready_o;

  always_comb begin
    valid_d    = valid_q;
    rd_idx_d   = rd_idx_q;
    rd_wen_d   = rd_wen_q;
    data_d     = data_q;
    csr_addr_d = csr_addr_q;
    csr_data_d = csr_data_q;
    csr_wen_d  = csr_wen_q;
    cnt_d      = cnt_q;
`ifdef WB_COMMIT_TRACE_EN
    pc_d       = pc_q;
    inst_d     = inst_q;
`endif
    if (retire) cnt_d = cnt_q + CNT_W'(1);
    // Flush wins; otherwise a new entry overwrites a retiring one for full throughput.
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      rd_idx_d   = rd_idx_i;
      rd_wen_d   = rd_wen_i;
      data_d     = fmt_data;
      csr_addr_d = csr_addr_i;
      csr_data_d = csr_data_i;
      csr_wen_d  = csr_wen_i;
`ifdef WB_COMMIT_TRACE_EN
      pc_d       = pc_i;
      inst_d     = inst_i;
`endif
    end else if (retire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rd_idx_q   <= '0;
      rd_wen_q   <= 1'b0;
      data_q     <= '0;
      csr_addr_q <= '0;
      csr_data_q <= '0;
      csr_wen_q  <= 1'b0;
      cnt_q      <= '0;
`ifdef WB_COMMIT_TRACE_EN
      pc_q       <= '0;
      inst_q     <= '0;
`endif
    end else begin
      valid_q    <= valid_d;
      rd_idx_q   <= rd_idx_d;
      rd_wen_q   <= rd_wen_d;
      data_q     <= data_d;
      csr_addr_q <= csr_addr_d;
      csr_data_q <= csr_data_d;
      csr_wen_q  <= csr_wen_d;
      cnt_q      <= cnt_d;
`ifdef WB_COMMIT_TRACE_EN
      pc_q       <= pc_d;
      inst_q     <= inst_d;
`endif
    end
  end

  assign gpr_wen_o    = retire && rd_wen_q && (rd_idx_q != '0);
  assign gpr_idx_o    = rd_idx_q;
  assign gpr_data_o   = data_q;
  assign csr_wen_o    = retire && csr_wen_q;
  assign csr_addr_o   = csr_addr_q;
  assign csr_data_o   = csr_data_q;
  assign retire_cnt_o = cnt_q;
`ifdef WB_COMMIT_TRACE_EN
  assign commit_valid_o = retire;
  assign commit_pc_o    = pc_q;
  assign commit_inst_o  = inst_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for wb_stage (default build, XLEN=64).
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [63:0] mem_data_i;
  logic [4:0]  rd_idx_i;
  logic        rd_wen_i;
  logic        load_en_i;
  logic [2:0]  load_f3_i;
  logic [2:0]  addr_lo_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_data_i;
  logic        csr_wen_i;
  logic        stall_i;
  logic        flush_i;
  logic        gpr_wen_o;
  logic [4:0]  gpr_idx_o;
  logic [63:0] gpr_data_o;
  logic        csr_wen_o;
  logic [11:0] csr_addr_o;
  logic [63:0] csr_data_o;
  logic [63:0] retire_cnt_o;

  wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid_i  (mem_valid_i),
    .mem_ready_o  (mem_ready_o),
    .mem_data_i   (mem_data_i),
    .rd_idx_i     (rd_idx_i),
    .rd_wen_i     (rd_wen_i),
    .load_en_i    (load_en_i),
    .load_f3_i    (load_f3_i),
    .addr_lo_i    (addr_lo_i),
    .csr_addr_i   (csr_addr_i),
    .csr_data_i   (csr_data_i),
    .csr_wen_i    (csr_wen_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .gpr_wen_o    (gpr_wen_o),
    .gpr_idx_o    (gpr_idx_o),
    .gpr_data_o   (gpr_data_o),
    .csr_wen_o    (csr_wen_o),
    .csr_addr_o   (csr_addr_o),
    .csr_data_o   (csr_data_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gw;
    logic [4:0]  idx;
    logic [63:0] d;
    logic        cw;
    logic [11:0] ca;
    logic [63:0] cd;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [4:0] rd,
                       input logic wen, input logic ld, input logic [2:0] f3,
                       input logic [2:0] lo, input logic [11:0] ca,
                       input logic [63:0] cd, input logic cw);
    mem_valid_i = v;   mem_data_i = d;   rd_idx_i  = rd;  rd_wen_i  = wen;
    load_en_i   = ld;  load_f3_i  = f3;  addr_lo_i = lo;
    csr_addr_i  = ca;  csr_data_i = cd;  csr_wen_i = cw;
  endtask

  task automatic push(input logic gw, input logic [4:0] idx, input logic [63:0] d,
                      input logic cw, input logic [11:0] ca, input logic [63:0] cd);
    exp_t e;
    e.gw = gw; e.idx = idx; e.d = d; e.cw = cw; e.ca = ca; e.cd = cd;
    sb.push_back(e);
  endtask

  // Any observed write strobe consumes the oldest expected write.
  task automatic mon();
    exp_t e;
    if (gpr_wen_o || csr_wen_o) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_gpr_wen", 64'(gpr_wen_o), 64'(e.gw));
        chk("sb_gpr_data", gpr_data_o, e.d);
        chk("sb_csr_wen", 64'(csr_wen_o), 64'(e.cw));
        if (e.gw) chk("sb_gpr_idx", 64'(gpr_idx_o), 64'(e.idx));
        if (e.cw) begin
          chk("sb_csr_addr", 64'(csr_addr_o), 64'(e.ca));
          chk("sb_csr_data", csr_data_o, e.cd);
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] ld_d   [7];
  logic [2:0]  ld_f3  [7];
  logic [2:0]  ld_lo  [7];
  logic        ld_en  [7];
  logic [63:0] ld_exp [7];

  initial begin
    ld_d[0] = 64'h0000_0000_0000_80FF; ld_f3[0] = 3'b000; ld_lo[0] = 3'd1; ld_en[0] = 1'b1; ld_exp[0] = 64'hFFFF_FFFF_FFFF_FF80;
    ld_d[1] = 64'h0000_0000_0000_80FF; ld_f3[1] = 3'b100; ld_lo[1] = 3'd1; ld_en[1] = 1'b1; ld_exp[1] = 64'h0000_0000_0000_0080;
    ld_d[2] = 64'h0000_0000_8001_0000; ld_f3[2] = 3'b001; ld_lo[2] = 3'd2; ld_en[2] = 1'b1; ld_exp[2] = 64'hFFFF_FFFF_FFFF_8001;
    ld_d[3] = 64'hDEAD_BEEF_8000_0000; ld_f3[3] = 3'b010; ld_lo[3] = 3'd4; ld_en[3] = 1'b1; ld_exp[3] = 64'hFFFF_FFFF_DEAD_BEEF;
    ld_d[4] = 64'hDEAD_BEEF_8000_0000; ld_f3[4] = 3'b110; ld_lo[4] = 3'd4; ld_en[4] = 1'b1; ld_exp[4] = 64'h0000_0000_DEAD_BEEF;
    ld_d[5] = 64'h0123_4567_89AB_CDEF; ld_f3[5] = 3'b011; ld_lo[5] = 3'd0; ld_en[5] = 1'b1; ld_exp[5] = 64'h0123_4567_89AB_CDEF;
    ld_d[6] = 64'hCAFE_BABE_1234_5678; ld_f3[6] = 3'b000; ld_lo[6] = 3'd3; ld_en[6] = 1'b0; ld_exp[6] = 64'hCAFE_BABE_1234_5678;

    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #22;
    @(negedge clk);
    chk("rst_gpr_wen", 64'(gpr_wen_o), 64'd0);
    chk("rst_csr_wen", 64'(csr_wen_o), 64'd0);
    chk("rst_gpr_data", gpr_data_o, 64'd0);
    chk("rst_cnt", retire_cnt_o, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rdy_after_rst", 64'(mem_ready_o), 64'd1);

    // Back-to-back loads and an ALU pass-through.
    for (int i = 0; i < 7; i++) begin
      drive(1, ld_d[i], 5'(i + 1), 1, ld_en[i], ld_f3[i], ld_lo[i], 0, 0, 0);
      push(1, 5'(i + 1), ld_exp[i], 0, 0, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("cnt_after_loads", retire_cnt_o, 64'd7);

    // Write to x0 retires but never strobes.
    drive(1, 64'h1234, 5'd0, 1, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    mon();
    chk("x0_gpr_wen", 64'(gpr_wen_o), 64'd0);
    chk("x0_data", gpr_data_o, 64'h1234);
    @(posedge clk); #1;
    chk("cnt_after_x0", retire_cnt_o, 64'd8);

    // csrrw: GPR and CSR write in the same cycle.
    drive(1, 64'h77, 5'd5, 1, 0, 0, 0, 12'h300, 64'hA, 1);
    push(1, 5'd5, 64'h77, 1, 12'h300, 64'hA);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("csrrw_both", 64'(gpr_wen_o && csr_wen_o), 64'd1);
    mon();
    @(posedge clk); #1;
    chk("cnt_after_csrrw", retire_cnt_o, 64'd9);

    // Stream of four with a two-cycle stall.
    drive(1, 64'h100, 5'd10, 1, 0, 0, 0, 0, 0, 0); push(1, 5'd10, 64'h100, 0, 0, 0);
    cyc();
    drive(1, 64'h101, 5'd11, 1, 0, 0, 0, 0, 0, 0); push(1, 5'd11, 64'h101, 0, 0, 0);
    cyc();
    drive(1, 64'h102, 5'd12, 1, 0, 0, 0, 0, 0, 0); push(1, 5'd12, 64'h102, 0, 0, 0);
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_ready", 64'(mem_ready_o), 64'd0);
      chk("stall_gpr_wen", 64'(gpr_wen_o), 64'd0);
      chk("stall_hold_data", gpr_data_o, 64'h101);
      mon();
      @(posedge clk); #1;
    end
    chk("cnt_during_stall", retire_cnt_o, 64'd10);
    stall_i = 1'b0;
    cyc();
    drive(1, 64'h103, 5'd13, 1, 0, 0, 0, 0, 0, 0); push(1, 5'd13, 64'h103, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("cnt_after_stall_stream", retire_cnt_o, 64'd13);

    // Flush while stalled: no write, no count, incoming entry dropped.
    drive(1, 64'h200, 5'd20, 1, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 64'h201, 5'd21, 1, 0, 0, 0, 0, 0, 0);
    stall_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_ready", 64'(mem_ready_o), 64'd0);
    mon();
    @(posedge clk); #1;
    stall_i = 1'b0; flush_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_no_wen", 64'(gpr_wen_o), 64'd0);
    chk("flush_ready_after", 64'(mem_ready_o), 64'd1);
    mon();
    @(posedge clk); #1;
    chk("cnt_after_flush", retire_cnt_o, 64'd13);

    // Flush without stall: retiring entry still writes and counts.
    drive(1, 64'h300, 5'd22, 1, 0, 0, 0, 0, 0, 0); push(1, 5'd22, 64'h300, 0, 0, 0);
    cyc();
    drive(1, 64'h301, 5'd23, 1, 0, 0, 0, 0, 0, 0);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("cnt_after_flush_retire", retire_cnt_o, 64'd14);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    // Asynchronous reset while an entry is held.
    drive(1, 64'h400, 5'd24, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_wen", 64'(gpr_wen_o), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_gpr_wen", 64'(gpr_wen_o), 64'd0);
    chk("midrst_cnt", retire_cnt_o, 64'd0);
    chk("midrst_data", gpr_data_o, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", 64'(mem_ready_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Registered, parametrised writeback stage between the MEM/WB boundary and the GPR/CSR regfiles.
- Adds three things over a pass-through writeback:
  - one pipeline register with a valid/ready handshake;
  - load-data alignment and sign/zero extension by funct3;
  - a retired-instruction counter.
- Drives the GPR write port and the CSR write port from the same registered entry.

Parameters:
- XLEN, 64, datapath width; 32 or 64.
- REG_AW, 5, GPR index width.
- CSR_AW, 12, CSR address width.
- CNT_W, 64, retire counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_valid_i  in  1  upstream entry valid.
- mem_ready_o  out  1  stage can accept this cycle.
- mem_data_i  in  XLEN  ALU result or raw load doubleword.
- rd_idx_i  in  REG_AW  destination GPR.
- rd_wen_i  in  1  instruction writes a GPR.
- load_en_i  in  1  mem_data_i is raw load data.
- load_f3_i  in  3  load funct3 (LB/LH/LW/LD/LBU/LHU/LWU).
- addr_lo_i  in  3  load address bits [2:0].
- csr_addr_i  in  CSR_AW  CSR address.
- csr_data_i  in  XLEN  CSR write data.
- csr_wen_i  in  1  CSR write request.
- stall_i  in  1  regfile side cannot take a write this cycle.
- flush_i  in  1  trap/redirect kill of the held entry.
- gpr_wen_o  out  1  GPR write strobe.
- gpr_idx_o  out  REG_AW  GPR write index.
- gpr_data_o  out  XLEN  GPR write data.
- csr_wen_o  out  1  CSR write strobe.
- csr_addr_o  out  CSR_AW  CSR write address.
- csr_data_o  out  XLEN  CSR write data.
- retire_cnt_o  out  CNT_W  number of retired entries.

Behaviour:
- Reset (rst_n low, asynchronous): valid_q=0, all held fields=0, retire_cnt_o=0. All strobes and data outputs are 0 while in reset.
- mem_ready_o = !flush_i && (!valid_q || !stall_i). It is combinational and does not depend on mem_valid_i.
- Accept when mem_valid_i && mem_ready_o:
  - data is formatted combinationally, then captured into the stage on the clock edge;
  - latency from accept to write strobes is 1 cycle.
- Load formatting when load_en_i=1:
  - shift mem_data_i right by addr_lo_i*8;
  - take the low 8/16/32/64 bits per funct3 [1:0];
  - sign-extend if funct3[2]=0, else zero-extend.
  - When load_en_i=0, data passes unchanged.
  - When XLEN=32: LD/LWU funct3 are treated as LW; addr_lo_i[2] is ignored.
  - Misaligned offsets are not checked; the shift result is used as-is, because exceptions are raised upstream.
- Write strobes:
  - gpr_wen_o = valid_q && !stall_i && rd_wen_q && (rd_idx_q != 0). A write to x0 is never issued.
  - csr_wen_o = valid_q && !stall_i && csr_wen_q.
  - Both strobes may assert in the same cycle (csrrw).
- Retire: an entry retires in the cycle valid_q && !stall_i. retire_cnt_o increments by 1 on that edge and wraps modulo 2^CNT_W.
- Retire and accept in the same cycle: valid_q stays 1 and the new entry loads (full throughput).
- Retire without accept: valid_q clears to 0.
- stall_i high:
  - the entry holds; both strobes are 0; no increment;
  - mem_ready_o=0 if valid_q=1.
- flush_i high:
  - valid_q clears on the next edge and nothing is accepted;
  - strobes are still gated by stall_i only, so an entry retiring in the flush cycle still writes and counts.
  - Flush has priority over accept.
- Data outputs show the held fields regardless of strobe state.

Optional Feature:
- WB_COMMIT_TRACE_EN, when defined:
  - adds inputs pc_i (XLEN) and inst_i (32), which are held alongside the entry;
  - adds outputs commit_valid_o (= retire condition), commit_pc_o and commit_inst_o, for the difftest/trace hookup.
- When undefined: those ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package/header sysconfig holds:
  - XLEN, REG_AW, CSR_AW defaults;
  - load funct3 encodings (F3_LB=000, F3_LH=001, F3_LW=010, F3_LD=011, F3_LBU=100, F3_LHU=101, F3_LWU=110).
- One natural sub-module: wb_load_fmt, a purely combinational aligner/extender (mem_data, addr_lo, funct3 → formatted data).
- The stage register, handshake and counter stay in wb_stage.

Test Plan:
- Reset mid-stream: assert rst_n=0 while valid_q=1 → strobes drop at once; retire_cnt_o=0; mem_ready_o=1 after release.
- LB, data=0x00000000_0000_80FF, addr_lo=1 → gpr_data_o=0xFFFF_FFFF_FFFF_FF80 one cycle after accept. Same input with LBU → 0x80.
- rd_idx_i=0, rd_wen_i=1, data=0x1234 → gpr_wen_o stays 0; retire_cnt_o still increments by 1.
- csrrw with rd=5, csr=0x300, csr_data=0xA → gpr_wen_o and csr_wen_o both 1 in the same cycle, with matching idx/addr/data.
- Back-to-back valids with stall_i pulsed for 2 cycles mid-stream → entry held, mem_ready_o=0 for 2 cycles, no strobes; after release, 4 inputs yield 4 retires in order and retire_cnt_o=4.
- flush_i with valid_q=1 and stall_i=1 → no write, no count, valid_q=0 next cycle, incoming entry not accepted.
